// File: rtl/gated_logic_pipe_if.sv
// gated_logic_pipe_if
// Purpose: groups the operand/handshake/result signals of gated_logic_pipe.
// Signals:
//   a, b, c    [WIDTH]   operand vectors, lane i uses bit i of each
//   mode       [2]       function select, travels with the operands
//   in_valid / in_ready  input handshake
//   d          [WIDTH]   per-lane result
//   ones       [ONES_W]  popcount of d
//   out_valid / out_ready output handshake
// Modports: master = upstream/downstream environment, slave = the pipe.
interface gated_logic_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int ONES_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  c;
  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  d;
  logic [ONES_W-1:0] ones;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output a, b, c, mode, in_valid, out_ready,
    input  in_ready, d, ones, out_valid
  );

  modport slave (
    input  a, b, c, mode, in_valid, out_ready,
    output in_ready, d, ones, out_valid
  );
endinterface

// File: rtl/gated_logic_pipe.sv
// gated_logic_pipe
// Purpose: two-stage valid/ready pipeline computing a per-lane gated logic
// function of a, b, c selected by mode, plus the popcount of the result and
// a saturating counter of delivered non-zero results.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       gated_logic_pipe_if.slave (operands, mode, handshakes, d, ones)
//   clr_hits  synchronous clear of hits (wins over a same-cycle increment)
//   hits      [CNT_W] saturating count of delivered results with d != 0
module gated_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  gated_logic_pipe_if.slave bus,
  input  logic              clr_hits,
  output logic [CNT_W-1:0]  hits
);
  localparam int ONES_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] HITS_MAX = {CNT_W{1'b1}};

  // Per-lane function selected by mode.
  function automatic logic [WIDTH-1:0] lane_fn(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    case (m)
      2'd0:    r = ~(x | y) & z;
      2'd1:    r = (x | y) & z;
      2'd2:    r = ~(x & y) & z;
      2'd3:    r = (x ^ y) & z;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Number of set bits in a result word.
  function automatic logic [ONES_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [ONES_W-1:0] cnt;
    cnt = {ONES_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        cnt = cnt + ONES_W'(1);
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  logic              s1_valid_r;
  logic [WIDTH-1:0]  s1_data_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  d_r;
  logic [ONES_W-1:0] ones_r;
  logic [CNT_W-1:0]  hits_r;

  logic s2_load_s;
  logic s1_load_s;
  logic in_xfer_s;
  logic out_xfer_s;

  // Stage load conditions; S1 may refill in the same cycle S2 drains, so a
  // full pipe with out_ready high keeps accepting one input per cycle.
  always_comb begin
    out_xfer_s = out_valid_r & bus.out_ready;
    s2_load_s  = ~out_valid_r | bus.out_ready;
    s1_load_s  = ~s1_valid_r | s2_load_s;
    in_xfer_s  = bus.in_valid & bus.in_ready;
  end

  // in_ready is forced low while reset is held.
  assign bus.in_ready  = s1_load_s & ~rst;
  assign bus.out_valid = out_valid_r;
  assign bus.d         = d_r;
  assign bus.ones      = ones_r;
  assign hits          = hits_r;

  // Stage 1: capture the function result together with its own mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {WIDTH{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= in_xfer_s;
      if (in_xfer_s) begin
        s1_data_r <= lane_fn(bus.mode, bus.a, bus.b, bus.c);
      end
    end
  end

  // Stage 2: result and popcount; held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      d_r         <= {WIDTH{1'b0}};
      ones_r      <= {ONES_W{1'b0}};
    end else if (s2_load_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        d_r    <= s1_data_r;
        ones_r <= popcount(s1_data_r);
      end
    end
  end

  // Saturating hit counter; clear takes priority over a counted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_r <= {CNT_W{1'b0}};
    end else if (clr_hits) begin
      hits_r <= {CNT_W{1'b0}};
    end else if (out_xfer_s && (d_r != {WIDTH{1'b0}}) && (hits_r != HITS_MAX)) begin
      hits_r <= hits_r + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_gated_logic_pipe.sv
// tb_gated_logic_pipe
// Purpose: self-checking bench for gated_logic_pipe (WIDTH=8, CNT_W=2).
// A queue-based scoreboard predicts handshakes, results and hits each cycle;
// directed scenarios add explicit constant expectations on top.
module tb_gated_logic_pipe;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int HMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  logic clr_hits;
  logic [CNT_W-1:0] hits;

  gated_logic_pipe_if #(.WIDTH(WIDTH)) bus ();

  gated_logic_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .clr_hits (clr_hits),
    .hits     (hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         acc;
  } item_t;

  item_t q[$];
  int    edge_no  = 0;
  int    exp_hits = 0;
  int    obs_out  = 0;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference function, lane by lane with boolean operators.
  function automatic logic [7:0] ref_fn(input int m, input logic [7:0] x,
                                        input logic [7:0] y, input logic [7:0] z);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      bit p, s;
      p = x[i];
      s = y[i];
      case (m)
        0:       r[i] = !(p || s) && z[i];
        1:       r[i] = (p || s) && z[i];
        2:       r[i] = !(p && s) && z[i];
        default: r[i] = (p != s) && z[i];
      endcase
    end
    return r;
  endfunction

  task automatic set(input int m, input logic [7:0] va, input logic [7:0] vb,
                     input logic [7:0] vc, input bit iv, input bit ordy, input bit clr);
    bus.mode      = m[1:0];
    bus.a         = va;
    bus.b         = vb;
    bus.c         = vc;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    clr_hits      = clr;
  endtask

  // One clock: check outputs against the scoreboard, then advance it.
  task automatic tick(output bit in_x);
    bit         out_x;
    bit         exp_rdy;
    bit         exp_ov;
    logic [7:0] nd;
    #2;
    // Full pipe only refuses input while the consumer stalls.
    exp_rdy = !(q.size() == 2 && !bus.out_ready);
    // A lone item is still in the first stage on the edge it was taken.
    exp_ov  = (q.size() >= 2) || (q.size() == 1 && q[0].acc != edge_no);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("out_valid", bus.out_valid, exp_ov);
    if (exp_ov) begin
      chk("d", bus.d, q[0].d);
      chk("ones", bus.ones, $countones(q[0].d));
    end
    chk("hits", hits, exp_hits);
    in_x  = bus.in_valid && exp_rdy;
    out_x = exp_ov && bus.out_ready;
    nd    = ref_fn(int'(bus.mode), bus.a, bus.b, bus.c);
    if (bus.out_valid && bus.out_ready) obs_out++;
    @(posedge clk);
    edge_no++;
    if (clr_hits) exp_hits = 0;
    else if (out_x && q[0].d != 8'h00 && exp_hits < HMAX) exp_hits++;
    if (out_x) void'(q.pop_front());
    if (in_x) q.push_back('{d: nd, acc: edge_no});
    #1;
  endtask

  initial begin
    bit         acc;
    int         k;
    int         h0;
    int         n0;
    logic [7:0] vals [4];
    int         sat_exp [5];

    vals    = '{8'h11, 8'h22, 8'h33, 8'h44};
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset state
    rst = 1'b1;
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_hits", hits, 0);
    chk("rst_d", bus.d, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // Basic path: mode 0
    set(0, 8'h0F, 8'h30, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick(acc);
    chk("basic_acc", acc, 1'b1);
    set(0, 8'h0F, 8'h30, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick(acc);
    #1;
    chk("basic_valid", bus.out_valid, 1'b1);
    chk("basic_d", bus.d, 8'hC0);
    chk("basic_ones", bus.ones, 2);
    tick(acc);
    #1;
    chk("basic_hits", hits, 1);

    // All modes back to back, mode captured per transaction
    set(1, 8'h0F, 8'h30, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick(acc);
    set(2, 8'h0F, 8'h30, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick(acc);
    #1;
    chk("m1_d", bus.d, 8'h3F);
    chk("m1_ones", bus.ones, 6);
    set(3, 8'h0F, 8'h30, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick(acc);
    #1;
    chk("m2_d", bus.d, 8'hFF);
    chk("m2_ones", bus.ones, 8);
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(acc);
    #1;
    chk("m3_d", bus.d, 8'h3F);
    chk("m3_ones", bus.ones, 6);
    tick(acc);
    tick(acc);

    // Zero result leaves hits unchanged
    h0 = exp_hits;
    set(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'h00, 1'b1, 1'b1, 1'b0);
    tick(acc);
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(acc);
    #1;
    chk("zero_valid", bus.out_valid, 1'b1);
    chk("zero_d", bus.d, 8'h00);
    chk("zero_ones", bus.ones, 0);
    tick(acc);
    #1;
    chk("zero_hits", hits, h0);

    // Back-pressure: only two inputs fit while stalled
    k = 0;
    for (int i = 0; i < 4; i++) begin
      set(3, vals[k], 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
      tick(acc);
      if (acc) k++;
    end
    chk("bp_accepted", k, 2);
    #1;
    chk("bp_hold_d", bus.d, 8'h11);
    n0 = obs_out;
    for (int i = 0; i < 8; i++) begin
      set(3, vals[(k < 4) ? k : 3], 8'h00, 8'hFF, k < 4, 1'b1, 1'b0);
      tick(acc);
      if (acc) k++;
    end
    chk("bp_all_accepted", k, 4);
    chk("bp_delivered", obs_out - n0, 4);

    // Saturation of a 2-bit counter, then clear on a counted transfer
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick(acc);
    #1;
    chk("sat_clear", hits, 0);
    for (int j = 0; j < 5; j++) begin
      set(3, 8'(j + 1), 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
      tick(acc);
      set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      tick(acc);
      tick(acc);
      #1;
      chk($sformatf("sat_hits_%0d", j), hits, sat_exp[j]);
    end
    set(3, 8'h5A, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick(acc);
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(acc);
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick(acc);
    #1;
    chk("clr_wins", hits, 0);
    clr_hits = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
          ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 24) == 0);
      tick(acc);
    end
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(acc);

    // Make sure hits is non-zero, then fill both stages
    set(1, 8'h01, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick(acc);
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(acc);
    tick(acc);
    for (int i = 0; i < 3; i++) begin
      set(1, 8'h0F, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
      tick(acc);
    end
    // Reset mid-flight, asserted away from the clock edge
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_hits", hits, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    chk("mid_rst_d", bus.d, 8'h00);
    chk("mid_rst_ones", bus.ones, 0);
    q.delete();
    exp_hits = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ready", bus.in_ready, 1'b1);
    set(2, 8'hF0, 8'hF0, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick(acc);
    set(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    n0 = obs_out;
    for (int i = 0; i < 5; i++) tick(acc);
    chk("mid_rst_single_result", obs_out - n0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gated_logic_pipe.md
GATED_LOGIC_PIPE -- requirements
Module: gated_logic_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the lane count (bits per operand), legal range 1..32.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the hit-counter width, legal range 2..32.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 a, b, c  input  WIDTH each  operand vectors, lane i uses bit i of each.
REQ-007 mode  input  2  function select, sampled together with the operands.
REQ-008 in_valid  input  1  operands and mode are valid this cycle.
REQ-009 in_ready  output  1  block accepts an input this cycle.
REQ-010 d  output  WIDTH  per-lane result.
REQ-011 ones  output  $clog2(WIDTH+1)  count of 1 bits in d.
REQ-012 out_valid  output  1  d/ones hold a valid result.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 hits  output  CNT_W  saturating count of delivered results with d != 0.
REQ-015 clr_hits  input  1  synchronous clear of hits.

Function
REQ-016 Per lane, the function SHALL be: mode 0: ~(a|b)&c; mode 1: (a|b)&c; mode 2: ~(a&b)&c; mode 3: (a^b)&c.
REQ-017 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-018 The pipeline SHALL have two register stages: S1 registers the function result, S2 registers d and its popcount ones.
REQ-019 With no stall, latency from input transfer to out_valid SHALL be exactly 2 cycles, at one result per cycle.
REQ-020 S2 SHALL load when S2 is empty or an output transfer occurs in the same cycle.
REQ-021 S1 SHALL load when S1 is empty or S1 advances to S2 in the same cycle.
REQ-022 in_ready SHALL be the S1 load condition. It SHALL be combinational from out_ready and the stage valid bits, never from in_valid.
REQ-023 While out_valid && !out_ready, d, ones and out_valid SHALL hold stable.
REQ-024 Results SHALL leave in input order, with none dropped or duplicated.
REQ-025 mode SHALL be captured per transaction, so a mode change mid-stream affects only subsequent inputs.
REQ-026 On each output transfer with d != 0, hits SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-027 clr_hits SHALL set hits to 0 on the next edge. If clr_hits coincides with a counted transfer, the clear SHALL win and hits becomes 0.
REQ-028 A simultaneous input transfer and output transfer with both stages full SHALL sustain full throughput with no bubble.

Reset
REQ-029 On rst assertion, S1 valid, S2 valid, out_valid, d, ones and hits SHALL go to 0 immediately, without waiting for a clock edge.
REQ-030 During rst, in_ready SHALL be 0. It SHALL be 1 in the first cycle after deassertion.
REQ-031 rst asserted mid-operation SHALL discard all in-flight results. No result accepted before reset SHALL appear after it.

Verification
REQ-032 Directed scenario, basic path: WIDTH=8, mode 0, a=0x0F, b=0x30, c=0xFF, out_ready=1 -> d=0xC0 and ones=2 exactly 2 cycles after acceptance; hits=1.
REQ-033 Directed scenario, all modes: mode 1/2/3 with a=0x0F, b=0x30, c=0xFF -> d = 0x3F / 0xFF / 0x3F respectively, ones = 6 / 8 / 6, results in order.
REQ-034 Directed scenario, back-pressure: 4 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepted, d stays stable; then out_ready=1 -> all 4 results delivered in order, with no loss and no duplicate.
REQ-035 Directed scenario, saturation: CNT_W=2, 5 transfers each with d!=0 -> hits reads 1,2,3,3,3. Then clr_hits on a counted transfer -> hits=0.
REQ-036 Directed scenario, reset mid-flight: rst asserted with both stages full -> out_valid=0 and hits=0 immediately; after release, a single input yields exactly one result.
REQ-037 Directed scenario, zero result: c=0x00 in any mode -> d=0, ones=0, hits unchanged.
